// File: rtl/ps2_key_rx_if.sv
// Key-event bus between the PS/2 receiver and its consumer: show-ahead FIFO
// head, occupancy, pop request and the one-cycle error/overflow pulses.
interface ps2_key_rx_if #(
    parameter int ADDR_W = 3
) ();
    logic              evt_rd;
    logic              evt_valid;
    logic [9:0]        evt_data;
    logic [ADDR_W:0]   evt_count;
    logic              parity_err;
    logic              frame_err;
    logic              overflow;

    modport master (
        input  evt_rd,
        output evt_valid, evt_data, evt_count, parity_err, frame_err, overflow
    );

    modport slave (
        output evt_rd,
        input  evt_valid, evt_data, evt_count, parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronise and filter ps2clk/ps2data, frame 11-bit
// packets, decode E0/F0 prefixes into key events and queue them in a FIFO.
module ps2_key_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000,
    parameter int ADDR_W      = 3,
    parameter bit BREAK_ONLY  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2clk,
    input  logic               ps2data,
    ps2_key_rx_if.master       evt
);
    localparam int HALF   = FILTER_LEN / 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Synchronisers and ps2clk glitch filter
    // ------------------------------------------------------------------
    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] filter_q;
    logic                  fall_edge_q;
    logic                  data_s;

    assign data_s = data_sync_q[1];

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            filter_q    <= '0;
            fall_edge_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2clk};
            data_sync_q <= {data_sync_q[0], ps2data};
            filter_q    <= {filter_q[FILTER_LEN-2:0], clk_sync_q[1]};
            fall_edge_q <= (&filter_q[FILTER_LEN-1:HALF]) && !(|filter_q[HALF-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // Framer with mid-frame timeout
    // ------------------------------------------------------------------
    logic [3:0]        bit_cnt_q;
    logic [9:0]        shift_q;
    logic [IDLE_W-1:0] idle_q;
    logic              byte_valid_q;
    logic [7:0]        byte_q;
    logic              parity_err_q;
    logic              frame_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            idle_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall_edge_q) begin
                idle_q <= '0;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= '0;
                    // Start/stop failures take priority over parity.
                    if (shift_q[0] || !data_s) begin
                        frame_err_q <= 1'b1;
                    end else if (!(^shift_q[9:1])) begin
                        parity_err_q <= 1'b1;
                    end else begin
                        byte_valid_q <= 1'b1;
                        byte_q       <= shift_q[8:1];
                    end
                end else begin
                    shift_q[bit_cnt_q] <= data_s;
                    bit_cnt_q          <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (idle_q == IDLE_LAST) begin
                    bit_cnt_q   <= '0;
                    idle_q      <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    idle_q <= idle_q + IDLE_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } dec_state_e;

    dec_state_e state_q;
    logic       push_q;
    logic [9:0] push_data_q;
    logic       cur_ext;
    logic       cur_brk;

    assign cur_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    assign cur_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (parity_err_q || frame_err_q) begin
                state_q <= S_IDLE;
            end else if (byte_valid_q) begin
                if (byte_q == 8'hE0) begin
                    state_q <= S_EXT;
                end else if (byte_q == 8'hF0) begin
                    if (state_q == S_IDLE)
                        state_q <= S_BRK;
                    else if (state_q == S_EXT)
                        state_q <= S_EXT_BRK;
                end else begin
                    push_q      <= !BREAK_ONLY || cur_brk;
                    push_data_q <= {cur_ext, cur_brk, byte_q};
                    state_q     <= S_IDLE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------
    logic [9:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              do_pop;
    logic              do_push;
    logic              full;

    assign full    = (count_q == CNT_FULL);
    assign do_pop  = evt.evt_rd && (count_q != '0);
    assign do_push = push_q && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_q && full && !do_pop;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the head is masked
    // while empty, so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_q;
    end

    assign evt.evt_valid  = (count_q != '0);
    assign evt.evt_data   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign evt.evt_count  = count_q;
    assign evt.parity_err = parity_err_q;
    assign evt.frame_err  = frame_err_q;
    assign evt.overflow   = overflow_q;
endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Parametrised PS/2 keyboard receiver: it replaces the single-byte, break-only receiver in the keyboard-to-display path. It filters and synchronises `ps2clk`/`ps2data` and frames 11-bit packets with start, parity and stop checking. It decodes the E0 (extended) and F0 (break) prefixes into key events and buffers them in a show-ahead FIFO, which the display/control logic pops at its own pace. It runs in the pixel-clock domain and adds error reporting plus a mid-frame timeout.

## Interface
Parameters:
- `FILTER_LEN`, 8: length of the ps2clk sample shift register; even, ≥4.
- `TIMEOUT_CYC`, 25000: clk cycles without a falling edge mid-frame before the frame is aborted; ≥16.
- `ADDR_W`, 3: FIFO address width; depth = 2**ADDR_W.
- `BREAK_ONLY`, 0:
  - 1 = enqueue break events only (legacy behaviour).
  - 0 = enqueue make and break events.

Ports:
- `clk` in 1: pixel clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ps2clk` in 1: raw PS/2 clock, asynchronous.
- `ps2data` in 1: raw PS/2 data, asynchronous.
- `evt_rd` in 1: pop request; honoured only while `evt_valid`=1.
- `evt_valid` out 1: FIFO not empty.
- `evt_data` out 10: head event {ext, brk, code[7:0]}.
- `evt_count` out ADDR_W+1: current FIFO occupancy.
- `parity_err` out 1: one-cycle pulse, parity fail.
- `frame_err` out 1: one-cycle pulse on bad start bit, bad stop bit, or timeout.
- `overflow` out 1: one-cycle pulse, event dropped because the FIFO was full.

## Operation
- **Synchronisers.**
  - `ps2clk` and `ps2data` each pass through a 2-flop synchroniser.
  - Synchronised `ps2clk` shifts into `FILTER_LEN` samples (newest at bit 0).
  - `fall_edge` = upper half all ones AND lower half all zeros.
  - `fall_edge` is registered, so it is a 1-cycle pulse.
- **Framer.**
  - Bit counter runs 0..10. On each `fall_edge`, synchronised `ps2data` is captured at index = counter, and the counter increments.
  - Bit 0 is the start bit, bits 1..8 are data (LSB first), bit 9 is odd parity, bit 10 is the stop bit.
  - On the edge that captures bit 10, the counter returns to 0 and the frame is checked:
    - start≠0 or stop≠1 → `frame_err`.
    - Otherwise, XOR of bits 1..9 ≠1 → `parity_err`.
    - Otherwise, byte_valid with byte = bits 1..8.
  - Both errors set at once: only `frame_err` pulses.
- **Timeout.**
  - The idle counter clears on every `fall_edge` and increments while bit counter ≠0.
  - When it reaches `TIMEOUT_CYC`: bit counter → 0, `frame_err` pulses, decoder → IDLE.
- **Decoder FSM.** States: IDLE, EXT, BRK, EXT_BRK.
  - 0xE0: IDLE→EXT.
  - 0xF0: IDLE→BRK, EXT→EXT_BRK.
  - Any other byte: emit event {ext = state∈{EXT, EXT_BRK}, brk = state∈{BRK, EXT_BRK}, code = byte}, then → IDLE.
  - 0xE0 received in EXT/BRK/EXT_BRK: state → EXT, with prior prefixes discarded.
  - 0xF0 received in BRK/EXT_BRK: state unchanged.
  - Any `parity_err`/`frame_err` forces → IDLE.
  - If `BREAK_ONLY`=1, events with brk=0 are discarded without a push.
- **FIFO** (show-ahead, depth 2**ADDR_W).
  - `evt_data` = head entry whenever `evt_valid`=1. Its value while empty is don't-care, but it is 0 after reset.
  - Push while not full: stored.
  - Push while full with no pop: event dropped, `overflow` pulses, contents unchanged.
  - Push and pop in the same cycle while full: both performed, count unchanged, no overflow.
  - Pop while empty: ignored.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo the depth; the count saturates at neither end beyond these rules.

## Timing
- **Reset** (asynchronous on `reset`=0):
  - Synchronisers and filter to all zeros, so no false edge follows reset.
  - Bit counter, idle counter and FIFO pointers to 0; FSM to IDLE.
  - All outputs 0 (`evt_valid`=0, `evt_data`=0, `evt_count`=0, all error pulses 0).
  - Reset asserted mid-frame or mid-prefix discards all partial state.
- **Edge detection:** `fall_edge` asserts `FILTER_LEN`/2 + 3 cycles after raw `ps2clk` falls, provided the input is stable.
- **Event latency**, counted from the `fall_edge` of the stop bit (cycle N):
  - byte_valid or error pulse at N+1.
  - FIFO push at N+2.
  - `evt_valid`/`evt_count` update visible at N+3.
- **Pop:** `evt_rd` at cycle M → new head and count visible at M+1.
- **Throughput:** sustains back-to-back frames at any PS/2 rate with ≥`FILTER_LEN` clk cycles per half-period.

## Test plan
- **Make, plain key.** Reset; send 0x1C with BREAK_ONLY=0 → one event 0x01C, `evt_valid` rises exactly 3 cycles after the stop `fall_edge`, `evt_count`=1.
- **Extended break.** Send 0xE0, 0xF0, 0x75 → a single event 0x375 (ext=1, brk=1). Repeat with BREAK_ONLY=1 and 0x1C alone → no event.
- **Errors.**
  - Frame with wrong parity → `parity_err` pulse, no event.
  - Frame with stop=0 → `frame_err` pulse, no event.
  - 0xF0 followed by a bad frame, then 0x1C → event 0x01C (brk=0).
- **Timeout.** Send 5 bits then stop for `TIMEOUT_CYC` cycles → `frame_err` pulse at that cycle. A complete 0x2D frame sent afterwards → event 0x02D.
- **Overflow and full boundary.**
  - ADDR_W=2: push 5 events without reading → `evt_count`=4, one `overflow` pulse, head = first event.
  - Pop and push in the same cycle while full → no overflow, count stays 4.
- **Reset mid-operation.** Assert `reset` mid-frame with 3 events queued → all outputs 0 immediately. A following complete frame decodes correctly.
